// File: rtl/music_sheet_player.sv
// Replays a note sheet from a synchronous-read RAM: fetches each entry, sounds
// its note for dur*TICK_DIV cycles and stops at an end marker or LastAddress.
module music_sheet_player #(
  parameter int TICK_DIV = 1000,
  parameter int ADDR_W   = 5,
  parameter int NOTE_W   = 4,
  parameter int DUR_W    = 4
) (
  input  logic                    Clock,
  input  logic                    Reset,
  input  logic                    Play,
  input  logic                    Stop,
  input  logic [ADDR_W-1:0]       LastAddress,
  output logic [ADDR_W-1:0]       ReadAddress,
  input  logic [NOTE_W+DUR_W-1:0] ReadData,
  output logic [NOTE_W-1:0]       NoteCode,
  output logic                    NoteValid,
  output logic                    Playing,
  output logic                    Done
);

  localparam int TICK_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] FETCH = 3'd1;
  localparam logic [2:0] LOAD  = 3'd2;
  localparam logic [2:0] PLAY  = 3'd3;
  localparam logic [2:0] DONE  = 3'd4;

  logic [2:0]        state;
  logic              play_p1;
  logic [TICK_W-1:0] tick_cnt;
  logic [DUR_W-1:0]  dur_cnt;

  logic [NOTE_W-1:0] rd_note;
  logic [DUR_W-1:0]  rd_dur;
  logic              play_rise;
  logic              tick_wrap;
  logic              note_end;
  logic              at_last;

  assign rd_note   = ReadData[NOTE_W+DUR_W-1:DUR_W];
  assign rd_dur    = ReadData[DUR_W-1:0];
  assign play_rise = Play & ~play_p1;
  assign tick_wrap = (tick_cnt == TICK_LAST);
  assign note_end  = tick_wrap && (dur_cnt == DUR_W'(1));
  // LastAddress is compared live so the writer may still be extending the sheet
  assign at_last   = (ReadAddress == LastAddress);

  assign Playing = (state != IDLE);
  assign Done    = (state == DONE);

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state       <= IDLE;
      play_p1     <= 1'b0;
      tick_cnt    <= '0;
      dur_cnt     <= '0;
      ReadAddress <= '0;
      NoteCode    <= '0;
      NoteValid   <= 1'b0;
    end else begin
      play_p1 <= Play;
      if (Stop && (state != IDLE)) begin
        // Abort: clear everything, no Done pulse
        state       <= IDLE;
        tick_cnt    <= '0;
        dur_cnt     <= '0;
        ReadAddress <= '0;
        NoteCode    <= '0;
        NoteValid   <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (play_rise && !Stop) begin
              ReadAddress <= '0;
              state       <= FETCH;
            end
          end
          FETCH: begin
            state <= LOAD;
          end
          LOAD: begin
            if (rd_dur == '0) begin
              state <= DONE;
            end else begin
              NoteCode  <= rd_note;
              dur_cnt   <= rd_dur;
              tick_cnt  <= '0;
              NoteValid <= (rd_note != '0);
              state     <= PLAY;
            end
          end
          PLAY: begin
            if (tick_wrap) begin
              tick_cnt <= '0;
              dur_cnt  <= dur_cnt - 1'b1;
            end else begin
              tick_cnt <= tick_cnt + 1'b1;
            end
            if (note_end) begin
              NoteValid <= 1'b0;
              if (at_last) begin
                state <= DONE;
              end else begin
                ReadAddress <= ReadAddress + 1'b1;
                state       <= FETCH;
              end
            end
          end
          DONE: begin
            NoteCode    <= '0;
            ReadAddress <= '0;
            tick_cnt    <= '0;
            dur_cnt     <= '0;
            state       <= IDLE;
          end
          default: begin
            state <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_music_sheet_player.sv
// Scoreboard bench for music_sheet_player: expected note/done events are queued
// by the stimulus and consumed by a negedge monitor.
module tb_music_sheet_player;

  localparam int TD = 4;

  logic       Clock = 1'b0;
  logic       Reset;
  logic       Play;
  logic       Stop;
  logic [4:0] LastAddress;
  logic [4:0] ReadAddress;
  logic [7:0] ReadData;
  logic [3:0] NoteCode;
  logic       NoteValid;
  logic       Playing;
  logic       Done;

  logic [7:0] mem [32];

  music_sheet_player #(.TICK_DIV(TD), .ADDR_W(5), .NOTE_W(4), .DUR_W(4)) dut (
    .Clock(Clock), .Reset(Reset), .Play(Play), .Stop(Stop),
    .LastAddress(LastAddress), .ReadAddress(ReadAddress), .ReadData(ReadData),
    .NoteCode(NoteCode), .NoteValid(NoteValid), .Playing(Playing), .Done(Done)
  );

  always #5 Clock = ~Clock;

  always @(posedge Clock) ReadData <= mem[ReadAddress];

  typedef struct {
    int kind;   // 0 = note, 1 = done
    int code;
    int len;    // note: sounding cycles; done: Playing cycles before the pulse
    int addr;
  } ev_t;

  ev_t q[$];
  int  checks = 0;
  int  errors = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic push_note(input int code, input int len, input int addr);
    ev_t e;
    e.kind = 0; e.code = code; e.len = len; e.addr = addr;
    q.push_back(e);
  endtask

  task automatic push_done(input int len, input int addr);
    ev_t e;
    e.kind = 1; e.code = 0; e.len = len; e.addr = addr;
    q.push_back(e);
  endtask

  task automatic step();
    @(posedge Clock);
    #1;
  endtask

  task automatic start();
    Play = 1'b1;
    step();
    Play = 1'b0;
  endtask

  task automatic drain(input string name, input int max);
    int n;
    n = 0;
    while ((q.size() != 0 || Playing) && n < max) begin
      step();
      n++;
    end
    chk({name, "_drain_timeout"}, (n >= max) ? 1 : 0, 0);
    chk({name, "_queue_left"}, q.size(), 0);
  endtask

  task automatic check_idle(input string name);
    chk({name, "_Playing"}, int'(Playing), 0);
    chk({name, "_NoteValid"}, int'(NoteValid), 0);
    chk({name, "_NoteCode"}, int'(NoteCode), 0);
    chk({name, "_ReadAddress"}, int'(ReadAddress), 0);
    chk({name, "_Done"}, int'(Done), 0);
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 32; i++) mem[i] = 8'h00;
  endtask

  // Monitor
  int  pcount = 0;
  int  dec = 0;
  int  cur_code = 0;
  int  cur_len = 0;
  int  cur_addr = 0;
  bit  nv_prev = 0;
  bit  pl_prev = 0;
  int  addr_prev = 0;

  initial begin
    ev_t e;
    forever begin
      @(negedge Clock);
      if (Reset) begin
        pcount = 0; dec = 0; cur_len = 0;
        nv_prev = 0; pl_prev = 0; addr_prev = 0;
      end else begin
        if (Playing && !Done) pcount++;
        if (Playing && pl_prev && int'(ReadAddress) < addr_prev) dec++;
        if (NoteValid && !nv_prev) begin
          cur_code = int'(NoteCode);
          cur_addr = int'(ReadAddress);
          cur_len  = 0;
        end
        if (NoteValid) cur_len++;
        if (!NoteValid && nv_prev) begin
          if (q.size() == 0) begin
            chk("unexpected_note", 1, 0);
          end else begin
            e = q.pop_front();
            chk("note_kind", 0, e.kind);
            chk("note_code", cur_code, e.code);
            chk("note_len", cur_len, e.len);
            chk("note_addr", cur_addr, e.addr);
          end
        end
        if (Done) begin
          if (q.size() == 0) begin
            chk("unexpected_done", 1, 0);
          end else begin
            e = q.pop_front();
            chk("done_kind", 1, e.kind);
            chk("done_cycles", pcount, e.len);
            chk("done_addr", int'(ReadAddress), e.addr);
            chk("done_addr_decrease", dec, 0);
          end
          pcount = 0;
          dec = 0;
        end
        if (!Playing) begin
          pcount = 0;
          dec = 0;
        end
        nv_prev   = NoteValid;
        pl_prev   = Playing;
        addr_prev = int'(ReadAddress);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    Reset = 1'b1; Play = 1'b0; Stop = 1'b0; LastAddress = 5'd5;
    clear_mem();
    repeat (2) @(posedge Clock);
    #1;
    check_idle("reset");
    Reset = 1'b0;
    step();

    // Two notes then end marker; address 3 is never reached
    clear_mem();
    mem[0] = 8'h32; mem[1] = 8'h51; mem[2] = 8'h00; mem[3] = 8'h77;
    LastAddress = 5'd5;
    push_note(3, 2*TD, 0);
    push_note(5, 1*TD, 1);
    push_done(18, 2);
    start();
    chk("t1_fetch_addr", int'(ReadAddress), 0);
    chk("t1_fetch_playing", int'(Playing), 1);
    step();
    step();
    chk("t1_first_code", int'(NoteCode), 3);
    chk("t1_first_valid", int'(NoteValid), 1);
    drain("t1", 200);
    check_idle("t1_end");

    // LastAddress=1 ends after address 1; Play held high must not retrigger
    clear_mem();
    mem[0] = 8'h12; mem[1] = 8'h23; mem[2] = 8'h45;
    LastAddress = 5'd1;
    push_note(1, 2*TD, 0);
    push_note(2, 3*TD, 1);
    push_done(24, 1);
    Play = 1'b1;
    step();
    drain("t2", 200);
    repeat (3) step();
    check_idle("t2_held");
    Play = 1'b0;
    step();

    // Rest entry: playing but silent
    clear_mem();
    mem[0] = 8'h03;
    LastAddress = 5'd5;
    push_done(16, 1);
    start();
    repeat (6) step();
    chk("t3_rest_playing", int'(Playing), 1);
    chk("t3_rest_valid", int'(NoteValid), 0);
    chk("t3_rest_code", int'(NoteCode), 0);
    drain("t3", 200);

    // Stop mid-note at address 2, then restart from 0
    clear_mem();
    mem[0] = 8'h11; mem[1] = 8'h21; mem[2] = 8'h34;
    LastAddress = 5'd5;
    push_note(1, TD, 0);
    push_note(2, TD, 1);
    push_note(3, 6, 2);
    start();
    n = 0;
    while (!(ReadAddress == 5'd2 && NoteValid) && n < 200) begin
      step();
      n++;
    end
    chk("t4_wait_timeout", (n >= 200) ? 1 : 0, 0);
    repeat (5) step();
    Stop = 1'b1;
    step();
    Stop = 1'b0;
    check_idle("t4_stop");
    repeat (3) step();
    chk("t4_queue", q.size(), 0);
    chk("t4_still_idle", int'(Playing), 0);
    push_note(1, TD, 0);
    push_note(2, TD, 1);
    push_note(3, 4*TD, 2);
    push_done(32, 3);
    start();
    chk("t4_restart_addr", int'(ReadAddress), 0);
    drain("t4", 300);

    // Second Play edge while playing is ignored; async reset mid-note
    clear_mem();
    mem[0] = 8'h1F;
    LastAddress = 5'd5;
    start();
    n = 0;
    while (!NoteValid && n < 50) begin
      step();
      n++;
    end
    chk("t5_wait_timeout", (n >= 50) ? 1 : 0, 0);
    repeat (3) step();
    start();
    step();
    chk("t5_replay_playing", int'(Playing), 1);
    chk("t5_replay_valid", int'(NoteValid), 1);
    chk("t5_replay_addr", int'(ReadAddress), 0);
    @(posedge Clock);
    #2;
    Reset = 1'b1;
    #1;
    check_idle("t5_async_reset");
    @(negedge Clock);
    #1;
    Reset = 1'b0;
    step();
    check_idle("t5_after_reset");

    // Full 32-entry sheet, no wrap to 0
    for (int i = 0; i < 32; i++) mem[i] = 8'h11;
    LastAddress = 5'd31;
    for (int i = 0; i < 32; i++) push_note(1, TD, i);
    push_done(32*(TD+2), 31);
    start();
    drain("t6", 400);
    check_idle("t6_end");

    // Stop together with a Play edge in IDLE: no start
    clear_mem();
    mem[0] = 8'h11;
    LastAddress = 5'd0;
    Play = 1'b1;
    Stop = 1'b1;
    step();
    Play = 1'b0;
    Stop = 1'b0;
    step();
    step();
    check_idle("t7_stop_wins");
    chk("t7_queue", q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/music_sheet_player.md
Name: music_sheet_player

Overview:
- Downstream consumer of the music sheet writer: replays the 32-entry note sheet the writer filled.
- Steps sheet addresses 0..LastAddress, fetches each entry from the sheet RAM (synchronous read, 1-cycle latency) and holds its note code for its duration.
- Feeds NoteCode/NoteValid to the tone generator, which maps codes to frequencies.

Parameters:
- TICK_DIV, 1000: Clock cycles per duration tick; range 2..65535.
- ADDR_W, 5: sheet address width, giving 32 entries.
- NOTE_W, 4: note code width; code 0 is a rest.
- DUR_W, 4: duration field width, in ticks; 0 is the end-of-sheet marker.

Ports:
- Clock  in  1  system clock; all state changes on its rising edge.
- Reset  in  1  asynchronous, active-high.
- Play  in  1  level input; a rising edge (sampled against a registered copy) starts playback.
- Stop  in  1  level input; aborts playback.
- LastAddress  in  ADDR_W  last valid sheet address; the writer's CurrentAddress.
- ReadAddress  out  ADDR_W  sheet RAM read address.
- ReadData  in  NOTE_W+DUR_W  RAM data for the previous cycle's ReadAddress; note code in the upper NOTE_W bits, duration in the lower DUR_W bits.
- NoteCode  out  NOTE_W  current note code.
- NoteValid  out  1  high while a non-rest note sounds.
- Playing  out  1  high in any state except IDLE.
- Done  out  1  one-cycle pulse at natural end of sheet.

Behaviour:
- Reset values: all outputs 0; state IDLE; Play-edge register 0; tick and duration counters 0. Reset mid-playback forces this immediately, asynchronously.
- States:
  - IDLE: outputs held at reset values. A Play rising edge with Stop=0 sets ReadAddress=0 and goes to FETCH.
  - FETCH: one cycle, waits for RAM latency; then LOAD.
  - LOAD: captures ReadData.
    - Duration field 0: go to DONE; NoteCode is not updated.
    - Otherwise: NoteCode gets the note field, duration counter gets the duration field, tick counter gets 0, go to PLAY.
  - PLAY: NoteValid=1 iff NoteCode!=0.
    - Tick counter counts 0..TICK_DIV-1 and wraps; on wrap the duration counter decrements.
    - When the duration counter reaches 0, NoteValid goes to 0 in the same edge.
    - If ReadAddress==LastAddress, go to DONE; else ReadAddress+1 and go to FETCH.
  - DONE: Done=1 and Playing=1 for exactly one cycle; NoteCode cleared to 0; then IDLE.
- Timing:
  - Play edge sampled at edge n: ReadAddress=0 and FETCH after edge n; PLAY entered with NoteCode valid after edge n+2.
  - Each note sounds exactly dur×TICK_DIV cycles.
  - Inter-note gap is 2 cycles (FETCH, LOAD) with NoteValid=0 and NoteCode holding the old value.
- Stop:
  - Stop=1 in any state other than IDLE goes to IDLE on the next edge with outputs cleared; Done is not pulsed.
  - Stop and a Play edge together in IDLE: Stop wins and playback does not start.
- Play edges while Playing=1 are ignored; no restart.
- Address wrap: ReadAddress never increments past LastAddress. LastAddress=31 ends after address 31, with no wrap to 0.
- LastAddress is sampled every comparison, not latched at start.
- Held Play: a Play held high after completion does not retrigger; a new rising edge is required.

Test Plan:
- TICK_DIV=4, sheet {0x32, 0x51, 0x00}, LastAddress=5, Play pulsed -> NoteCode=3 for 8 cycles, 2-cycle gap, NoteCode=5 for 4 cycles, end marker -> Done pulse, never reads address 3.
- Sheet {0x12, 0x23}, LastAddress=1 -> plays codes 1 then 2, Done after address 1 with ReadAddress=1, then IDLE with outputs 0.
- Rest entry 0x03 at address 0 -> Playing=1, NoteValid=0 for 12 cycles, NoteCode=0.
- Stop asserted mid-note at address 2 -> IDLE next cycle, ReadAddress=0, NoteValid=0, no Done. A later Play edge restarts from address 0.
- Reset asserted asynchronously between clock edges during PLAY -> all outputs 0 before the next edge. A second Play edge while Playing=1 -> no restart.
- All 32 entries 0x11 with LastAddress=31 -> 32 notes, Done after address 31, ReadAddress never shows wrap to 0 before Done.
